// File: rtl/dispatch_pkg.sv
// Dispatch-local types: op class, controller state and the opcode-to-class mapping.
package dispatch_pkg;
    import rv32i_types::*;

    typedef enum logic [2:0] {CLS_ALU, CLS_MUL, CLS_BR, CLS_MEM, CLS_ILL} disp_class_t;
    typedef enum logic {RUN, HALT} disp_state_t;

    function automatic disp_class_t classify(input logic [6:0] opc, input logic [6:0] f7);
        disp_class_t cls;
        case (opc)
            op_reg:                                    cls = (f7 == funct7_muldiv) ? CLS_MUL : CLS_ALU;
            op_lui, op_auipc, op_imm, op_jal, op_jalr: cls = CLS_ALU;
            op_br:                                     cls = CLS_BR;
            op_load, op_store:                         cls = CLS_MEM;
            default:                                   cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcode constants, ALU op encoding and the decode-stage record.
package rv32i_types;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    localparam logic [6:0] funct7_muldiv = 7'b0000001;

    typedef enum logic [2:0] {
        alu_op_add = 3'b000,
        alu_op_sll = 3'b001,
        alu_op_sra = 3'b010,
        alu_op_sub = 3'b011,
        alu_op_xor = 3'b100,
        alu_op_srl = 3'b101,
        alu_op_or  = 3'b110,
        alu_op_and = 3'b111
    } alu_ops;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
        alu_ops      aluop;
        logic [2:0]  cmpop;
    } decode_stage_reg_t;

endpackage

// File: rtl/dispatch_ctrl_decode.sv
// Combinational RV32I field extraction; fields an opcode does not define are driven to 0.
module dispatch_ctrl_decode
    import rv32i_types::*;
(
    input  logic [31:0]       i_inst,
    output decode_stage_reg_t o_op
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_imm_i = {{21{i_inst[31]}}, i_inst[30:20]};
    assign w_imm_s = {{21{i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
    assign w_imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'h000};
    assign w_imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    function automatic alu_ops alu_sel(input logic [2:0] f3, input logic alt);
        alu_ops op;
        case (f3)
            3'b000:  op = alt ? alu_op_sub : alu_op_add;
            3'b001:  op = alu_op_sll;
            3'b100:  op = alu_op_xor;
            3'b101:  op = alt ? alu_op_sra : alu_op_srl;
            3'b110:  op = alu_op_or;
            3'b111:  op = alu_op_and;
            default: op = alu_op_add;
        endcase
        return op;
    endfunction

    // slt/sltu run through the comparator as blt/bltu
    function automatic logic [2:0] slt_cmp(input logic [2:0] f3);
        logic [2:0] c;
        case (f3)
            3'b010:  c = 3'b100;
            3'b011:  c = 3'b110;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    always_comb begin
        o_op        = '0;
        o_op.opcode = w_opc;
        case (w_opc)
            op_lui, op_auipc: begin
                o_op.rd_addr = i_inst[11:7];
                o_op.imm     = w_imm_u;
            end
            op_jal: begin
                o_op.rd_addr = i_inst[11:7];
                o_op.imm     = w_imm_j;
            end
            op_jalr, op_load: begin
                o_op.rd_addr  = i_inst[11:7];
                o_op.rs1_addr = i_inst[19:15];
                o_op.funct3   = w_f3;
                o_op.imm      = w_imm_i;
            end
            op_br: begin
                o_op.rs1_addr = i_inst[19:15];
                o_op.rs2_addr = i_inst[24:20];
                o_op.funct3   = w_f3;
                o_op.cmpop    = w_f3;
                o_op.imm      = w_imm_b;
            end
            op_store: begin
                o_op.rs1_addr = i_inst[19:15];
                o_op.rs2_addr = i_inst[24:20];
                o_op.funct3   = w_f3;
                o_op.imm      = w_imm_s;
            end
            op_imm: begin
                o_op.rd_addr  = i_inst[11:7];
                o_op.rs1_addr = i_inst[19:15];
                o_op.funct3   = w_f3;
                o_op.imm      = w_imm_i;
                o_op.aluop    = alu_sel(w_f3, (w_f3 == 3'b101) & i_inst[30]);
                o_op.cmpop    = slt_cmp(w_f3);
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    o_op.funct7 = i_inst[31:25];
            end
            op_reg: begin
                o_op.rd_addr  = i_inst[11:7];
                o_op.rs1_addr = i_inst[19:15];
                o_op.rs2_addr = i_inst[24:20];
                o_op.funct3   = w_f3;
                o_op.funct7   = i_inst[31:25];
                if (i_inst[31:25] != funct7_muldiv) begin
                    o_op.aluop = alu_sel(w_f3, i_inst[30]);
                    o_op.cmpop = slt_cmp(w_f3);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-slot dispatch stage: decode, classify, route to RS and allocate ROB; halts on illegal ops.
// Optional DISPATCH_PERF_EN adds dispatch and stall performance counters.
module dispatch_ctrl
    import rv32i_types::*;
    import dispatch_pkg::*;
#(
    parameter int ROB_TAG_W = 4
`ifdef DISPATCH_PERF_EN
   ,parameter int PERF_W    = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq_valid,
    input  logic [31:0]          iq_inst,
    input  logic [31:0]          iq_pc,
    output logic                 iq_ready,
    input  logic                 rob_ready,
    input  logic [ROB_TAG_W-1:0] rob_tail_tag,
    output logic                 rob_alloc,
    input  logic                 alu_rs_ready,
    input  logic                 mul_rs_ready,
    input  logic                 br_rs_ready,
    input  logic                 mem_rs_ready,
    output logic                 alu_rs_valid,
    output logic                 mul_rs_valid,
    output logic                 br_rs_valid,
    output logic                 mem_rs_valid,
    output decode_stage_reg_t    disp_op,
    output logic [31:0]          disp_pc,
    output logic [ROB_TAG_W-1:0] disp_rob_tag,
    input  logic                 flush,
    output logic                 illegal
`ifdef DISPATCH_PERF_EN
   ,output logic [PERF_W-1:0]    perf_disp_cnt
   ,output logic [PERF_W-1:0]    perf_stall_cnt
`endif
);

    decode_stage_reg_t w_dec, r_slot_op;
    disp_class_t       w_cls, r_slot_cls;
    disp_state_t       r_state;
    logic              r_slot_valid, r_illegal;
    logic [31:0]       r_slot_pc;
    logic              w_rs_go, w_tgt_ready, w_fire, w_acc;

    dispatch_ctrl_decode u_decode (
        .i_inst (iq_inst),
        .o_op   (w_dec)
    );

    assign w_cls = classify(w_dec.opcode, w_dec.funct7);

    // RS valids are offered without looking at the RS ready
    assign w_rs_go = r_slot_valid & (r_state == RUN) & rob_ready & ~flush;

    always_comb begin
        w_tgt_ready = 1'b0;
        case (r_slot_cls)
            CLS_ALU: w_tgt_ready = alu_rs_ready;
            CLS_MUL: w_tgt_ready = mul_rs_ready;
            CLS_BR:  w_tgt_ready = br_rs_ready;
            CLS_MEM: w_tgt_ready = mem_rs_ready;
            default: w_tgt_ready = 1'b0;
        endcase
    end

    assign w_fire   = w_rs_go & w_tgt_ready;
    assign iq_ready = ~flush & (r_state == RUN) & (~r_slot_valid | w_fire);
    assign w_acc    = iq_valid & iq_ready;

    assign alu_rs_valid = w_rs_go & (r_slot_cls == CLS_ALU);
    assign mul_rs_valid = w_rs_go & (r_slot_cls == CLS_MUL);
    assign br_rs_valid  = w_rs_go & (r_slot_cls == CLS_BR);
    assign mem_rs_valid = w_rs_go & (r_slot_cls == CLS_MEM);
    assign rob_alloc    = w_fire;
    assign disp_rob_tag = rob_tail_tag;
    assign disp_op      = r_slot_op;
    assign disp_pc      = r_slot_pc;
    assign illegal      = r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_slot_valid <= 1'b0;
            r_slot_op    <= '0;
            r_slot_pc    <= '0;
            r_slot_cls   <= CLS_ALU;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_state      <= RUN;
            r_slot_valid <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_acc) begin
                        r_slot_valid <= 1'b1;
                        r_slot_op    <= w_dec;
                        r_slot_pc    <= iq_pc;
                        r_slot_cls   <= w_cls;
                        // halt the moment an undecodable op reaches the slot
                        if (w_cls == CLS_ILL) begin
                            r_state   <= HALT;
                            r_illegal <= 1'b1;
                        end
                    end else if (w_fire) begin
                        r_slot_valid <= 1'b0;
                    end
                end
                HALT: ;
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [PERF_W-1:0] r_perf_disp, r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_disp  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fire)
                r_perf_disp <= r_perf_disp + PERF_W'(1);
            if (r_slot_valid & ~w_fire & ~flush)
                r_perf_stall <= r_perf_stall + PERF_W'(1);
        end
    end

    assign perf_disp_cnt  = r_perf_disp;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
